bus_response_mux: RTL and testbench

- Parametrised successor to the core's combinational data bus multiplexer and its tied-high DTAck.
- Sits between the address decoder/slaves and the CPU read port. It takes one-hot slave selects and returns registered read data plus a DTAck handshake.
- Each slave either has a fixed latency or is ready-driven.
- Decode faults and unresponsive slaves raise a timeout bus error instead of returning silent zeros.

---
 rtl/bus_fabric_pkg.sv | 32 +++
 rtl/bus_response_mux_if.sv | 27 ++
 rtl/wait_counter.sv | 45 ++++
 rtl/bus_response_mux.sv | 156 +++++++++++++++
 tb/tb_bus_response_mux.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared bus-fabric types: transfer FSM states, default error pattern and a
// one-hot decode helper shared by the response mux and the graphics arbiter.
package bus_fabric_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERROR} bus_state_t;

  localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEADBEEF;
  localparam int unsigned MAX_SLAVES         = 16;
  localparam int unsigned IDX_W              = $clog2(MAX_SLAVES);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } onehot_t;

  // valid only when exactly one bit is set; idx is meaningless otherwise
  function automatic onehot_t onehot_index(input logic [MAX_SLAVES-1:0] vec);
    onehot_t     res;
    int unsigned ones;
    res.idx = '0;
    ones    = 0;
    for (int i = 0; i < MAX_SLAVES; i++) begin
      if (vec[i]) begin
        res.idx = IDX_W'(i);
        ones    = ones + 1;
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/bus_response_mux_if.sv
// CPU read-port / slave-side bundle of the response mux.
interface bus_response_mux_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32
);
  logic                         AS_L;
  logic                         WE_L;
  logic [31:0]                  Address;
  logic [NUM_SLAVES-1:0]        Select_H;
  logic [NUM_SLAVES-1:0]        Ready_H;
  logic [NUM_SLAVES*DATA_W-1:0] DataIn_Slaves;
  logic [DATA_W-1:0]            DataOut_CPU;
  logic                         DTAck_H;
  logic                         Bus_Error_H;
  logic [31:0]                  Error_Address;
  logic [7:0]                   Error_Count;

  modport master (
    output AS_L, WE_L, Address, Select_H, Ready_H, DataIn_Slaves,
    input  DataOut_CPU, DTAck_H, Bus_Error_H, Error_Address, Error_Count
  );

  modport slave (
    input  AS_L, WE_L, Address, Select_H, Ready_H, DataIn_Slaves,
    output DataOut_CPU, DTAck_H, Bus_Error_H, Error_Address, Error_Count
  );
endinterface

// File: rtl/wait_counter.sv
// Latency down-counter plus timeout up-counter with terminal detection.
module wait_counter #(
  parameter int unsigned LAT_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [LAT_W-1:0] lat_init,
  output logic             lat_done_c,
  output logic             to_done_c
);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    to_cnt_d  = to_cnt_q;
    if (load) begin
      lat_cnt_d = lat_init;
      to_cnt_d  = '0;
    end else if (step) begin
      if (lat_cnt_q != '0) lat_cnt_d = lat_cnt_q - LAT_W'(1);
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // timeout fires on the WAIT cycle that would bring to_cnt up to TIMEOUT_CYCLES
  assign lat_done_c = (lat_cnt_q == '0);
  assign to_done_c  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_response_mux.sv
// Registered slave read-data mux with DTAck handshake, per-slave fixed or
// ready-driven latency, and timeout/decode-fault bus errors with an error log.
module bus_response_mux
  import bus_fabric_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES       = 4,
  parameter int unsigned                  DATA_W           = 32,
  parameter int unsigned                  LAT_W            = 3,
  parameter logic [NUM_SLAVES*LAT_W-1:0]  SLAVE_LATENCY    = {3'd0, 3'd1, 3'd2, 3'd0},
  parameter logic [NUM_SLAVES-1:0]        SLAVE_READY_MODE = 4'b0100,
  parameter int unsigned                  TIMEOUT_CYCLES   = 255,
  parameter logic [DATA_W-1:0]            ERROR_DATA       = DATA_W'(DEFAULT_ERROR_DATA)
) (
  input  logic               Clock,
  input  logic               Reset_H,
  bus_response_mux_if.slave  bus
);

  bus_state_t            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  dtack_q, dtack_d;
  logic                  berr_q, berr_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [NUM_SLAVES-1:0] cur_sel_c;
  onehot_t               oh_c;
  logic [LAT_W-1:0]      cur_lat_c, lat_init_c;
  logic                  cur_ready_mode_c, cur_ready_c;
  logic [DATA_W-1:0]     cur_data_c;
  logic                  wc_load_c, wc_step_c, lat_done_c, to_done_c;
  logic                  go_ack_c, go_err_c;

  // target slave: live select while idle, captured select afterwards
  always_comb begin
    cur_sel_c        = (state_q == IDLE) ? bus.Select_H : sel_q;
    oh_c             = onehot_index(MAX_SLAVES'(cur_sel_c));
    cur_lat_c        = '0;
    cur_ready_mode_c = 1'b0;
    cur_ready_c      = 1'b0;
    cur_data_c       = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (oh_c.idx == IDX_W'(i)) begin
        cur_lat_c        = SLAVE_LATENCY[i*LAT_W +: LAT_W];
        cur_ready_mode_c = SLAVE_READY_MODE[i];
        cur_ready_c      = bus.Ready_H[i];
        cur_data_c       = bus.DataIn_Slaves[i*DATA_W +: DATA_W];
      end
    end
    lat_init_c = (cur_lat_c == '0) ? '0 : cur_lat_c - LAT_W'(1);
  end

  wait_counter #(
    .LAT_W          (LAT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk        (Clock),
    .rst        (Reset_H),
    .load       (wc_load_c),
    .step       (wc_step_c),
    .lat_init   (lat_init_c),
    .lat_done_c (lat_done_c),
    .to_done_c  (to_done_c)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    data_d     = data_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    wc_load_c  = 1'b0;
    wc_step_c  = 1'b0;
    go_ack_c   = 1'b0;
    go_err_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.AS_L) begin
          sel_d = bus.Select_H;
          we_d  = bus.WE_L;
          if (!oh_c.valid)                              go_err_c = 1'b1;
          else if (!cur_ready_mode_c && cur_lat_c == '0) go_ack_c = 1'b1;
          else begin
            state_d   = WAIT;
            wc_load_c = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.AS_L)                                          state_d  = IDLE;
        else if (cur_ready_mode_c ? cur_ready_c : lat_done_c) go_ack_c = 1'b1;
        else if (to_done_c)                                   go_err_c = 1'b1;
        else                                                  wc_step_c = 1'b1;
      end
      ACK, ERROR: begin
        if (bus.AS_L) begin
          state_d = IDLE;
          dtack_d = 1'b0;
          berr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_ack_c) begin
      state_d = ACK;
      data_d  = we_d ? cur_data_c : '0;
      dtack_d = 1'b1;
      berr_d  = 1'b0;
    end

    if (go_err_c) begin
      state_d    = ERROR;
      data_d     = ERROR_DATA;
      dtack_d    = 1'b1;
      berr_d     = 1'b1;
      err_addr_d = bus.Address;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      we_q       <= 1'b1;
      data_q     <= '0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      data_q     <= data_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.DataOut_CPU   = data_q;
  assign bus.DTAck_H       = dtack_q;
  assign bus.Bus_Error_H   = berr_q;
  assign bus.Error_Address = err_addr_q;
  assign bus.Error_Count   = err_cnt_q;

endmodule

// File: tb/tb_bus_response_mux.sv
// Scoreboard bench for bus_response_mux: latencies 0/1/2, ready mode, abort,
// reset mid-transfer, timeout and decode faults with error-count saturation.
module tb_bus_response_mux;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_response_mux_if #(.NUM_SLAVES(4), .DATA_W(32)) bus ();

  bus_response_mux #(
    .NUM_SLAVES       (4),
    .DATA_W           (32),
    .LAT_W            (3),
    .SLAVE_LATENCY    ({3'd2, 3'd0, 3'd1, 3'd0}),
    .SLAVE_READY_MODE (4'b0100),
    .TIMEOUT_CYCLES   (8),
    .ERROR_DATA       (32'hDEADBEEF)
  ) dut (
    .Clock   (clk),
    .Reset_H (rst),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    int          lat;
    logic        berr;
    logic [31:0] data;
    logic [31:0] eaddr;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_eaddr = '0;
  logic [7:0]  model_ecnt  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one strobed transfer; expectation queued before the strobe, checked on DTAck
  task automatic run_cycle(input string tag, input logic [3:0] sel, input logic we_l,
                           input logic [31:0] addr, input int ready_at, input int exp_lat,
                           input logic exp_berr, input logic [31:0] exp_data);
    exp_t e;
    int   n;
    if (exp_berr) begin
      model_eaddr = addr;
      if (model_ecnt != 8'hFF) model_ecnt = model_ecnt + 8'd1;
    end
    e.tag = tag; e.lat = exp_lat; e.berr = exp_berr; e.data = exp_data;
    e.eaddr = model_eaddr; e.ecnt = model_ecnt;
    sb_q.push_back(e);

    bus.Select_H = sel; bus.WE_L = we_l; bus.Address = addr; bus.AS_L = 1'b0;
    n = 0;
    while (n < 64) begin
      bus.Ready_H = (ready_at >= 0 && n >= ready_at) ? 4'b0100 : 4'b0000;
      tick();
      if (bus.DTAck_H) break;
      bus.Select_H = 4'b1000;
      n++;
    end

    e = sb_q.pop_front();
    check_eq({e.tag, "_lat"},   32'(n),               32'(e.lat));
    check_eq({e.tag, "_dtack"}, 32'(bus.DTAck_H),     32'd1);
    check_eq({e.tag, "_berr"},  32'(bus.Bus_Error_H), 32'(e.berr));
    check_eq({e.tag, "_data"},  bus.DataOut_CPU,      e.data);
    check_eq({e.tag, "_eaddr"}, bus.Error_Address,    e.eaddr);
    check_eq({e.tag, "_ecnt"},  32'(bus.Error_Count), 32'(e.ecnt));

    tick();
    check_eq({e.tag, "_hold_dtack"}, 32'(bus.DTAck_H), 32'd1);
    check_eq({e.tag, "_hold_data"},  bus.DataOut_CPU,  e.data);

    bus.AS_L = 1'b1; bus.Ready_H = 4'b0000;
    tick();
    check_eq({e.tag, "_rel_dtack"}, 32'(bus.DTAck_H),     32'd0);
    check_eq({e.tag, "_rel_berr"},  32'(bus.Bus_Error_H), 32'd0);
    check_eq({e.tag, "_rel_data"},  bus.DataOut_CPU,      e.data);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_data"},  bus.DataOut_CPU,      32'd0);
    check_eq({tag, "_dtack"}, 32'(bus.DTAck_H),     32'd0);
    check_eq({tag, "_berr"},  32'(bus.Bus_Error_H), 32'd0);
    check_eq({tag, "_eaddr"}, bus.Error_Address,    32'd0);
    check_eq({tag, "_ecnt"},  32'(bus.Error_Count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.AS_L = 1'b1; bus.WE_L = 1'b1; bus.Address = '0;
    bus.Select_H = '0; bus.Ready_H = '0;
    bus.DataIn_Slaves = {32'hCAFE0003, 32'h22222222, 32'h12345678, 32'h00500093};
    tick(); tick();
    rst = 1'b0;
    check_reset_state("por");
    tick();

    run_cycle("lat1_rd",   4'b0010, 1'b1, 32'h0001_0000, -1, 1, 1'b0, 32'h12345678);
    run_cycle("lat2_rd",   4'b1000, 1'b1, 32'h0003_0000, -1, 2, 1'b0, 32'hCAFE0003);
    run_cycle("lat0_rd",   4'b0001, 1'b1, 32'h0000_0010, -1, 0, 1'b0, 32'h00500093);
    run_cycle("lat0_wr",   4'b0001, 1'b0, 32'h0000_0014, -1, 0, 1'b0, 32'h0);
    run_cycle("lat1_wr",   4'b0010, 1'b0, 32'h0001_0004, -1, 1, 1'b0, 32'h0);
    run_cycle("rdy5_rd",   4'b0100, 1'b1, 32'h0002_0000,  5, 5, 1'b0, 32'h22222222);
    run_cycle("rdy0_rd",   4'b0100, 1'b1, 32'h0002_0008,  0, 1, 1'b0, 32'h22222222);

    // strobe released mid-WAIT: no acknowledge, no error logged
    bus.Select_H = 4'b0100; bus.WE_L = 1'b1; bus.Address = 32'h0002_0010; bus.AS_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("abort_wait_dtack", 32'(bus.DTAck_H), 32'd0);
    end
    bus.AS_L = 1'b1;
    tick();
    check_eq("abort_dtack", 32'(bus.DTAck_H),     32'd0);
    check_eq("abort_berr",  32'(bus.Bus_Error_H), 32'd0);
    check_eq("abort_ecnt",  32'(bus.Error_Count), 32'(model_ecnt));
    tick();
    check_eq("abort_idle_dtack", 32'(bus.DTAck_H), 32'd0);

    run_cycle("timeout",   4'b0100, 1'b1, 32'h0002_0ABC, -1, 8, 1'b1, 32'hDEADBEEF);
    run_cycle("rd_after_to", 4'b0010, 1'b1, 32'h0001_0020, -1, 1, 1'b0, 32'h12345678);

    // reset held two cycles in the middle of a WAIT
    bus.Select_H = 4'b0100; bus.Address = 32'h0002_0040; bus.AS_L = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; bus.AS_L = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_ecnt = '0; model_eaddr = '0;
    check_reset_state("rst_mid");
    tick();
    check_eq("rst_idle_dtack", 32'(bus.DTAck_H), 32'd0);

    run_cycle("dec_none",  4'b0000, 1'b1, 32'hF000_0000, -1, 0, 1'b1, 32'hDEADBEEF);
    run_cycle("dec_multi", 4'b0011, 1'b1, 32'hF000_0004, -1, 0, 1'b1, 32'hDEADBEEF);
    check_eq("dec_cnt2", 32'(bus.Error_Count), 32'd2);

    for (int i = 0; i < 300; i++) begin
      run_cycle("dec_sat", (i % 2 == 0) ? 4'b0000 : 4'b1100, 1'b1,
                32'hE000_0000 + 32'(i), -1, 0, 1'b1, 32'hDEADBEEF);
    end
    check_eq("dec_sat_final", 32'(bus.Error_Count), 32'h0000_00FF);
    run_cycle("rd_after_sat", 4'b0001, 1'b1, 32'h0000_0100, -1, 0, 1'b0, 32'h00500093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
